time_countdown: RTL and testbench

//  Down-counting mm:ss timer for the digital-clock design; the counterpart of the up-counting

---
 rtl/time_countdown.sv | 132 +++++++++++++
 tb/tb_time_countdown.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_countdown.sv
// Down-counting mm:ss timer with a per-second prescaler.
// Emits a 1-cycle second strobe on each decrement and a done pulse at 00:00.
module time_countdown #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] min_counter,
  output logic [5:0] sec_counter,
  output logic       second,
  output logic       running,
  output logic       done
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0] SMAX = 6'(SEC_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_e;

  state_e state_q, state_d;

  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          second_q, second_d;
  logic          done_q, done_d;
  logic          running_q, running_d;
  logic          tick;
  logic          nonzero;
  logic          last;

  function automatic logic [5:0] sat(input logic [5:0] v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  // Registered state, count, prescaler and output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      presc_q   <= '0;
      second_q  <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      second_q  <= second_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  // Command decode (load > pause > start) and per-second decrement
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    second_d = 1'b0;
    done_d   = 1'b0;
    tick     = (state_q == RUN) && (presc_q == P_LAST);
    nonzero  = (min_q != 6'd0) || (sec_q != 6'd0);
    last     = (min_q == 6'd0) && (sec_q == 6'd1);
    if (load) begin
      min_d   = sat(load_min);
      sec_d   = sat(load_sec);
      presc_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && nonzero) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
            // a swallowed tick stays pending so no second is lost
            if (!tick) presc_d = presc_q + PW'(1);
          end else if (tick) begin
            presc_d  = '0;
            second_d = 1'b1;
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else begin
              min_d = min_q - 6'd1;
              sec_d = SMAX;
            end
            if (last) begin
              done_d  = 1'b1;
              state_d = EXPIRED;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  assign min_counter = min_q;
  assign sec_counter = sec_q;
  assign second      = second_q;
  assign running     = running_q;
  assign done        = done_q;

endmodule

// File: tb/tb_time_countdown.sv
// Bench for time_countdown with CLK_HZ=4.
// Timestamped expectations are queued and checked at each falling edge.
module tb_time_countdown;

  logic       clk;
  logic       rst;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic [5:0] min_counter;
  logic [5:0] sec_counter;
  logic       second;
  logic       running;
  logic       done;

  time_countdown #(
    .CLK_HZ (4),
    .SEC_MAX(59)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .start      (start),
    .pause      (pause),
    .min_counter(min_counter),
    .sec_counter(sec_counter),
    .second     (second),
    .running    (running),
    .done       (done)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [5:0] m;
    logic [5:0] s;
    logic       sg;
    logic       rn;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   pass  = 0;
  int   total = 0;
  int   s;
  int   t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_at(input int c, input string nm,
                        input logic [5:0] m, input logic [5:0] sc,
                        input logic sg, input logic rn,
                        input logic dn);
    exp_t e;
    int   i;
    e.cyc = c;
    e.nm  = nm;
    e.m   = m;
    e.s   = sc;
    e.sg  = sg;
    e.rn  = rn;
    e.dn  = dn;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic drive(input logic ld, input logic [5:0] lm,
                       input logic [5:0] ls, input logic st,
                       input logic ps);
    load     = ld;
    load_min = lm;
    load_sec = ls;
    start    = st;
    pause    = ps;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic wait_edge(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (mon_e.cyc == cyc &&
          {min_counter, sec_counter, second, running, done} ===
          {mon_e.m, mon_e.s, mon_e.sg, mon_e.rn, mon_e.dn}) begin
        pass++;
      end else begin
        $display("FAIL %s cyc=%0d: got %0d:%0d sec=%b run=%b done=%b want %0d:%0d sec=%b run=%b done=%b",
                 mon_e.nm, cyc, min_counter, sec_counter, second,
                 running, done, mon_e.m, mon_e.s, mon_e.sg,
                 mon_e.rn, mon_e.dn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    load     = 1'b0;
    load_min = '0;
    load_sec = '0;
    start    = 1'b0;
    pause    = 1'b0;
    exp_at(1, "reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    s = cyc + 1;
    exp_at(s, "r_load", 1, 30, 0, 0, 0);
    drive(1, 1, 30, 0, 0);
    s = cyc + 1;
    exp_at(s + 4, "r_dec", 1, 29, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 5);
    exp_at(s + 6, "r_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({min_counter, sec_counter, second, running, done} === 15'd0)
      pass++;
    else
      $display("FAIL async_now: got %0d:%0d sec=%b run=%b done=%b",
               min_counter, sec_counter, second, running, done);
    @(negedge clk);
    rst = 1'b1;
    t = cyc + 1;
    exp_at(t + 1, "r_ign1", 0, 0, 0, 0, 0);
    exp_at(t + 5, "r_ign5", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(t + 6);

    s = cyc + 1;
    exp_at(s, "ld3", 0, 3, 0, 0, 0);
    drive(1, 0, 3, 0, 0);
    s = cyc + 1;
    exp_at(s, "run3", 0, 3, 0, 1, 0);
    exp_at(s + 3, "pre2", 0, 3, 0, 1, 0);
    exp_at(s + 4, "dec2", 0, 2, 1, 1, 0);
    exp_at(s + 5, "hold2", 0, 2, 0, 1, 0);
    exp_at(s + 8, "dec1", 0, 1, 1, 1, 0);
    exp_at(s + 11, "pre0", 0, 1, 0, 1, 0);
    exp_at(s + 12, "done", 0, 0, 1, 0, 1);
    exp_at(s + 13, "done_clr", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 14);
    t = cyc + 1;
    exp_at(t + 1, "exp_ign1", 0, 0, 0, 0, 0);
    exp_at(t + 6, "exp_ign6", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(t + 7);
    total++;
    if ({min_counter, sec_counter} === 12'd0 &&
        running === 1'b0 && done === 1'b0)
      pass++;
    else
      $display("FAIL exp_hold: got %0d:%0d run=%b done=%b",
               min_counter, sec_counter, running, done);

    s = cyc + 1;
    drive(1, 1, 0, 0, 0);
    s = cyc + 1;
    exp_at(s + 3, "b_pre", 1, 0, 0, 1, 0);
    exp_at(s + 4, "borrow", 0, 59, 1, 1, 0);
    exp_at(s + 5, "b_hold", 0, 59, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 6);

    drive(1, 0, 5, 0, 0);
    s = cyc + 1;
    exp_at(s + 4, "p_dec", 0, 4, 1, 1, 0);
    exp_at(s + 6, "paused", 0, 4, 0, 0, 0);
    exp_at(s + 15, "p_hold", 0, 4, 0, 0, 0);
    exp_at(s + 16, "resume", 0, 4, 0, 1, 0);
    exp_at(s + 17, "res_pre", 0, 4, 0, 1, 0);
    exp_at(s + 18, "res_dec", 0, 3, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 5);
    drive(0, 0, 0, 0, 1);
    wait_edge(s + 15);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 19);

    s = cyc + 1;
    exp_at(s, "sat", 59, 59, 0, 0, 0);
    drive(1, 63, 60, 0, 0);
    drive(1, 0, 0, 0, 0);
    s = cyc + 1;
    exp_at(s, "z_start", 0, 0, 0, 0, 0);
    exp_at(s + 4, "z_4", 0, 0, 0, 0, 0);
    exp_at(s + 8, "z_8", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 9);
    total++;
    if ({min_counter, sec_counter} === 12'd0 && running === 1'b0)
      pass++;
    else
      $display("FAIL z_idle: got %0d:%0d run=%b",
               min_counter, sec_counter, running);

    drive(1, 0, 2, 0, 0);
    s = cyc + 1;
    exp_at(s + 3, "l_pre", 0, 2, 0, 1, 0);
    exp_at(s + 4, "l_wins", 0, 2, 0, 0, 0);
    exp_at(s + 8, "l_idle", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 3);
    drive(1, 0, 2, 1, 0);
    wait_edge(s + 9);

    s = cyc + 1;
    exp_at(s + 3, "tp_pre", 0, 2, 0, 1, 0);
    exp_at(s + 4, "tp_pause", 0, 2, 0, 0, 0);
    exp_at(s + 8, "tp_hold", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    wait_edge(s + 3);
    drive(0, 0, 0, 0, 1);
    wait_edge(s + 10);

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++;
      $display("FAIL %s: never checked, want %0d:%0d",
               mon_e.nm, mon_e.m, mon_e.s);
    end
    $display("%0d/%0d checks passed", pass, total);
    if (pass == total && total > 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
